// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame size and baud divisor helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned FRAME_DATA_BITS = 8;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Free-running bit-period counter; tick marks the last cycle of each bit period.
module uart_baud_counter #(
  parameter int unsigned CLKS = 434,
  parameter int unsigned W    = (CLKS > 1) ? $clog2(CLKS) : 1
) (
  input  logic rd_clk,
  input  logic rd_rst,
  input  logic clear,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(CLKS - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge rd_clk) begin
    if (rd_rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame and sends 8N1/8N2, LSB first.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = clks_per_bit(50_000_000, 115_200),
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              i_tx_enable,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_rd_en,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_byte_done
);

  localparam int unsigned BAUD_W    = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [2:0]  LAST_BIT  = 3'(FRAME_DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t                  r_state, w_state_nxt;
  logic [FRAME_DATA_BITS-1:0] r_shreg, w_shreg_nxt;
  logic [2:0]                 r_bit, w_bit_nxt;
  logic                       r_tx, w_tx_nxt;
  logic                       r_done, w_done_nxt;
  logic                       w_tick;
  logic                       w_baud_clr;

  // Held clear until the first START cycle so every bit period starts at count 0.
  assign w_baud_clr = (r_state == IDLE) || (r_state == LOAD);

  uart_baud_counter #(
    .CLKS (CLKS_PER_BIT),
    .W    (BAUD_W)
  ) u_baud (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .clear  (w_baud_clr),
    .tick   (w_tick)
  );

  assign o_rd_en     = (r_state == IDLE) && !i_fifo_empty && i_tx_enable && !rd_rst;
  assign o_tx        = r_tx;
  assign o_busy      = (r_state != IDLE);
  assign o_byte_done = r_done;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // The bit counter also counts stop bits, so the baud counter only spans one bit.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (o_rd_en) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_shreg_nxt = i_rd_data[FRAME_DATA_BITS-1:0];
        w_tx_nxt    = 1'b0;
        w_state_nxt = START;
      end
      START: begin
        if (w_tick) begin
          w_tx_nxt    = r_shreg[0];
          w_shreg_nxt = {1'b0, r_shreg[FRAME_DATA_BITS-1:1]};
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit == LAST_BIT) begin
            w_tx_nxt    = 1'b1;
            w_bit_nxt   = '0;
            w_state_nxt = STOP;
          end else begin
            w_tx_nxt    = r_shreg[0];
            w_shreg_nxt = {1'b0, r_shreg[FRAME_DATA_BITS-1:1]};
            w_bit_nxt   = r_bit + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_bit == LAST_STOP) begin
            w_bit_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (4 clk/bit 1 stop, 3 clk/bit 2 stop) fed by FIFO models.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rd_rst;
  logic       en_a, empty_a, rden_a, tx_a, busy_a, done_a;
  logic [7:0] rd_data_a;
  logic       en_b, empty_b, rden_b, tx_b, busy_b, done_b;
  logic [7:0] rd_data_b;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .DATA_W(8)) u_a (
    .rd_clk(clk), .rd_rst(rd_rst), .i_tx_enable(en_a), .i_fifo_empty(empty_a),
    .i_rd_data(rd_data_a), .o_rd_en(rden_a), .o_tx(tx_a), .o_busy(busy_a),
    .o_byte_done(done_a)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2), .DATA_W(8)) u_b (
    .rd_clk(clk), .rd_rst(rd_rst), .i_tx_enable(en_b), .i_fifo_empty(empty_b),
    .i_rd_data(rd_data_b), .o_rd_en(rden_b), .o_tx(tx_b), .o_busy(busy_b),
    .o_byte_done(done_b)
  );

  logic [7:0] q_a[$], q_b[$];
  int         pops_a[$], pops_b[$], dones_a[$], dones_b[$];
  logic       log_a[0:8191];
  logic       log_b[0:8191];
  int         n = 0;
  int         n_pass = 0, n_total = 0, n_fail = 0;
  logic       last_rden_a, last_tx_a, last_busy_a, last_done_a;
  logic       last_tx_b, last_busy_b;
  logic [7:0] exp3[3];
  int         t0, t1, zeros;

  task automatic cyc();
    logic pa, pb;
    @(negedge clk);
    n++;
    if (n < 8192) begin
      log_a[n] = tx_a;
      log_b[n] = tx_b;
    end
    pa = rden_a;
    pb = rden_b;
    last_rden_a = rden_a; last_tx_a = tx_a; last_busy_a = busy_a; last_done_a = done_a;
    last_tx_b = tx_b; last_busy_b = busy_b;
    if (pa) pops_a.push_back(n);
    if (pb) pops_b.push_back(n);
    if (done_a) dones_a.push_back(n);
    if (done_b) dones_b.push_back(n);
    @(posedge clk);
    #1;
    if (pa && q_a.size() > 0) rd_data_a = q_a.pop_front();
    else rd_data_a = 8'($urandom);
    if (pb && q_b.size() > 0) rd_data_b = q_b.pop_front();
    else rd_data_b = 8'($urandom);
    empty_a = (q_a.size() == 0);
    empty_b = (q_b.size() == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input bit sel_b, input int t);
    if (t < 0 || t >= 8192) return 1'bx;
    return sel_b ? log_b[t] : log_a[t];
  endfunction

  function automatic int pop_at(input bit sel_b, input int i);
    if (sel_b) return (i < pops_b.size()) ? pops_b[i] : -1;
    return (i < pops_a.size()) ? pops_a[i] : -1;
  endfunction

  function automatic int done_at(input bit sel_b, input int i);
    if (sel_b) return (i < dones_b.size()) ? dones_b[i] : -1;
    return (i < dones_a.size()) ? dones_a[i] : -1;
  endfunction

  task automatic clear_logs();
    pops_a.delete(); pops_b.delete(); dones_a.delete(); dones_b.delete();
  endtask

  // Expected line per cycle: two idle-high gap cycles, start, 8 data bits LSB first, stop bits.
  task automatic check_frame(input bit sel_b, input int t, input logic [7:0] b,
                             input int c, input int s, input string tag);
    int   bi;
    logic e;
    chk({tag, "_gap0"}, line(sel_b, t), 1);
    chk({tag, "_gap1"}, line(sel_b, t + 1), 1);
    for (int k = 0; k < (9 + s) * c; k++) begin
      bi = k / c;
      if (bi == 0) e = 1'b0;
      else if (bi <= 8) e = b[bi-1];
      else e = 1'b1;
      chk($sformatf("%s_k%0d", tag, k), line(sel_b, t + 2 + k), e);
    end
  endtask

  task automatic push_a(input logic [7:0] b);
    q_a.push_back(b);
    empty_a = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] b);
    q_b.push_back(b);
    empty_b = 1'b0;
  endtask

  initial begin
    rd_rst = 1'b1;
    en_a = 1'b1; en_b = 1'b1;
    rd_data_a = '0; rd_data_b = '0;
    empty_a = 1'b1; empty_b = 1'b1;
    push_a(8'hA5);
    exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h3C;

    // Reset with a non-empty FIFO
    cyc();
    repeat (3) begin
      cyc();
      chk("rst_rden", last_rden_a, 0);
      chk("rst_tx", last_tx_a, 1);
      chk("rst_busy", last_busy_a, 0);
      chk("rst_done", last_done_a, 0);
      chk("rst_tx_b", last_tx_b, 1);
      chk("rst_busy_b", last_busy_b, 0);
    end

    // Single byte 0xA5
    rd_rst = 1'b0;
    clear_logs();
    t0 = n + 1;
    repeat (60) cyc();
    chk("t2_npop", pops_a.size(), 1);
    chk("t2_pop_t", pop_at(0, 0), t0);
    check_frame(0, t0, 8'hA5, 4, 1, "t2");
    chk("t2_ndone", dones_a.size(), 1);
    chk("t2_done_t", done_at(0, 0), t0 + 42);

    // Back-to-back bytes
    clear_logs();
    for (int i = 0; i < 3; i++) push_a(exp3[i]);
    t0 = n + 1;
    repeat (136) cyc();
    chk("t3_npop", pops_a.size(), 3);
    chk("t3_ndone", dones_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_pop%0d_t", i), pop_at(0, i), t0 + 42 * i);
      chk($sformatf("t3_done%0d_t", i), done_at(0, i), t0 + 42 * (i + 1));
      check_frame(0, t0 + 42 * i, exp3[i], 4, 1, $sformatf("t3_b%0d", i));
    end

    // Empty FIFO for 100 cycles
    clear_logs();
    t0 = n + 1;
    repeat (100) cyc();
    zeros = 0;
    for (int k = t0; k < t0 + 100; k++) if (line(0, k) !== 1'b1) zeros++;
    chk("t4a_npop", pops_a.size(), 0);
    chk("t4a_tx_low", zeros, 0);

    // Enable dropped during DATA of 0x5A
    clear_logs();
    push_a(8'h5A);
    push_a(8'h11);
    t0 = n + 1;
    repeat (15) cyc();
    en_a = 1'b0;
    repeat (70) cyc();
    chk("t4b_npop", pops_a.size(), 1);
    chk("t4b_pop_t", pop_at(0, 0), t0);
    check_frame(0, t0, 8'h5A, 4, 1, "t4b");
    chk("t4b_ndone", dones_a.size(), 1);
    chk("t4b_qleft", q_a.size(), 1);
    chk("t4b_busy", last_busy_a, 0);
    en_a = 1'b1;
    clear_logs();
    t1 = n + 1;
    repeat (50) cyc();
    chk("t4b_re_npop", pops_a.size(), 1);
    chk("t4b_re_pop_t", pop_at(0, 0), t1);
    check_frame(0, t1, 8'h11, 4, 1, "t4b_re");

    // Reset during bit 3 of 0x81
    clear_logs();
    push_a(8'h81);
    push_a(8'h42);
    t0 = n + 1;
    repeat (19) cyc();
    rd_rst = 1'b1;
    cyc();
    chk("t5_rden_in_rst", last_rden_a, 0);
    chk("t5_bit3_low", last_tx_a, 0);
    rd_rst = 1'b0;
    t1 = n + 1;
    cyc();
    chk("t5_tx_after_rst", last_tx_a, 1);
    chk("t5_busy_after_rst", last_busy_a, 0);
    repeat (50) cyc();
    chk("t5_npop", pops_a.size(), 2);
    chk("t5_pop0_t", pop_at(0, 0), t0);
    chk("t5_pop1_t", pop_at(0, 1), t1);
    check_frame(0, t1, 8'h42, 4, 1, "t5");
    chk("t5_ndone", dones_a.size(), 1);
    chk("t5_done_t", done_at(0, 0), t1 + 42);
    chk("t5_qleft", q_a.size(), 0);

    // Two stop bits at 3 clocks per bit
    clear_logs();
    push_b(8'h96);
    push_b(8'h69);
    t0 = n + 1;
    repeat (80) cyc();
    chk("t6_npop", pops_b.size(), 2);
    chk("t6_pop0_t", pop_at(1, 0), t0);
    chk("t6_pop1_t", pop_at(1, 1), t0 + 35);
    check_frame(1, t0, 8'h96, 3, 2, "t6_b0");
    check_frame(1, t0 + 35, 8'h69, 3, 2, "t6_b1");
    chk("t6_ndone", dones_b.size(), 2);
    chk("t6_done0_t", done_at(1, 0), t0 + 35);
    chk("t6_done1_t", done_at(1, 1), t0 + 70);
    chk("t6_a_quiet", pops_a.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
